// File: rtl/bus_arbiter.sv
// ============================================================================
//  Module   : bus_arbiter
//  Brief    : Round-robin owner-locked arbiter for the shared CPU memory bus.
//             Optional ack watchdog enabled by defining BUS_ARB_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter #(
   parameter int NM      = 3,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NM-1:0]        m_cyc_i,
   input  logic [NM-1:0]        m_stb_i,
   input  logic [NM-1:0]        m_we_i,
   input  logic [NM*AW-1:0]     m_adr_i,
   input  logic [NM*DW-1:0]     m_dat_i,
   input  logic [NM*DW/8-1:0]   m_sel_i,
   output logic [NM-1:0]        m_ack_o,
   output logic [NM-1:0]        m_err_o,
   output logic [DW-1:0]        m_dat_o,
   output logic                 s_cyc_o,
   output logic                 s_stb_o,
   output logic                 s_we_o,
   output logic [AW-1:0]        s_adr_o,
   output logic [DW-1:0]        s_dat_o,
   output logic [DW/8-1:0]      s_sel_o,
   input  logic                 s_ack_i,
   input  logic [DW-1:0]        s_dat_i,
   output logic [NM-1:0]        gnt_o,
   output logic                 busy_o
);

   localparam int IW = (NM > 1) ? $clog2(NM) : 1;
   localparam int SW = DW / 8;

   if (NM < 1 || NM > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
      $error("bus_arbiter: parameter out of range");
   end

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_OWNED = 1'b1
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [NM-1:0]   r_gnt, w_gnt_nxt;
   logic [IW-1:0]   r_last, w_last_nxt;
   logic [IW-1:0]   w_idx;
   logic            w_found;
   logic            w_tmo;
   logic            w_live;
   logic            w_own_cyc, w_own_stb, w_own_we;
   logic [AW-1:0]   w_own_adr;
   logic [DW-1:0]   w_own_dat;
   logic [SW-1:0]   w_own_sel;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_gnt   <= '0;
         r_last  <= IW'(NM - 1);
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_last  <= w_last_nxt;
      end
   end

   // Rotating scan starting one past the previous owner gives round-robin fairness.
   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_last_nxt  = r_last;
      w_idx       = '0;
      w_found     = 1'b0;
      case (r_state)
         S_IDLE: begin
            for (int i = 1; i <= NM; i++) begin
               w_idx = IW'((int'(r_last) + i) % NM);
               if (!w_found && m_cyc_i[w_idx]) begin
                  w_found        = 1'b1;
                  w_gnt_nxt      = '0;
                  w_gnt_nxt[w_idx] = 1'b1;
                  w_last_nxt     = w_idx;
                  w_state_nxt    = S_OWNED;
               end
            end
         end
         S_OWNED: begin
            if (!w_own_cyc || w_tmo) begin
               w_state_nxt = S_IDLE;
               w_gnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      w_own_cyc = |(m_cyc_i & r_gnt);
      w_own_stb = |(m_stb_i & r_gnt);
      w_own_we  = |(m_we_i & r_gnt);
      w_own_adr = '0;
      w_own_dat = '0;
      w_own_sel = '0;
      for (int k = 0; k < NM; k++) begin
         w_own_adr = w_own_adr | ({AW{r_gnt[k]}} & m_adr_i[k*AW +: AW]);
         w_own_dat = w_own_dat | ({DW{r_gnt[k]}} & m_dat_i[k*DW +: DW]);
         w_own_sel = w_own_sel | ({SW{r_gnt[k]}} & m_sel_i[k*SW +: SW]);
      end
   end

`ifdef BUS_ARB_TIMEOUT_EN
   logic [15:0] r_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt <= '0;
      end else if (r_state == S_IDLE || (w_live && s_ack_i)) begin
         r_cnt <= '0;
      end else if (s_stb_o) begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   assign w_tmo   = (r_state == S_OWNED) && (r_cnt == 16'(TIMEOUT));
   assign m_err_o = {NM{w_tmo}} & r_gnt;
`else
   assign w_tmo   = 1'b0;
   assign m_err_o = '0;
`endif

   // Watchdog expiry forces the slave cycle low for the cycle the error is reported.
   assign w_live  = (r_state == S_OWNED) && w_own_cyc && !w_tmo;

   assign s_cyc_o = w_live;
   assign s_stb_o = w_live & w_own_stb;
   assign s_we_o  = w_live & w_own_we;
   assign s_adr_o = w_live ? w_own_adr : '0;
   assign s_dat_o = w_live ? w_own_dat : '0;
   assign s_sel_o = w_live ? w_own_sel : '0;

   assign m_ack_o = {NM{w_live & s_ack_i}} & r_gnt;
   assign m_dat_o = s_dat_i;
   assign gnt_o   = r_gnt;
   assign busy_o  = (r_state == S_OWNED);

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed scenarios plus randomized masters,
// every cycle compared against a transaction-level ownership model.
`default_nettype none

module tb_bus_arbiter;

   localparam int NM = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
`ifdef BUS_ARB_TIMEOUT_EN
   localparam int TMO = 4;
`else
   localparam int TMO = 255;
`endif

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic [NM-1:0]      m_cyc_i, m_stb_i, m_we_i;
   logic [NM*AW-1:0]   m_adr_i;
   logic [NM*DW-1:0]   m_dat_i;
   logic [NM*SW-1:0]   m_sel_i;
   logic [NM-1:0]      m_ack_o, m_err_o;
   logic [DW-1:0]      m_dat_o;
   logic               s_cyc_o, s_stb_o, s_we_o;
   logic [AW-1:0]      s_adr_o;
   logic [DW-1:0]      s_dat_o;
   logic [SW-1:0]      s_sel_o;
   logic               s_ack_i;
   logic [DW-1:0]      s_dat_i;
   logic [NM-1:0]      gnt_o;
   logic               busy_o;

   bus_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
      .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
      .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
      .gnt_o(gnt_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: current owner (-1 when nobody owns the bus), last winner,
   // and the number of unacknowledged strobe cycles seen by the current owner.
   int own  = -1;
   int last = NM - 1;
   int wcnt = 0;

   logic [NM-1:0] cap_gnt, cap_ack, cap_err;
   logic [NM-1:0] grant_q[$];
   logic          prev_gnt_zero = 1'b1;
   int            ack_cnt, err_cnt;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic bit model_tmo();
`ifdef BUS_ARB_TIMEOUT_EN
      return (own >= 0) && (wcnt == TMO);
`else
      return 1'b0;
`endif
   endfunction

   task automatic compare_outputs();
      logic [NM-1:0] eg, ea, ee;
      logic          ec, es, ew, live;
      logic [AW-1:0] eadr;
      logic [DW-1:0] edat;
      logic [SW-1:0] esel;
      eg = '0; ea = '0; ee = '0; ec = 1'b0; es = 1'b0; ew = 1'b0;
      eadr = '0; edat = '0; esel = '0;
      if (own >= 0) begin
         eg[own] = 1'b1;
         live = m_cyc_i[own] && !model_tmo();
         if (model_tmo()) ee[own] = 1'b1;
         if (live) begin
            ec   = 1'b1;
            es   = m_stb_i[own];
            ew   = m_we_i[own];
            eadr = m_adr_i[own*AW +: AW];
            edat = m_dat_i[own*DW +: DW];
            esel = m_sel_i[own*SW +: SW];
            if (s_ack_i) ea[own] = 1'b1;
         end
      end
      check("gnt",   64'(gnt_o),   64'(eg));
      check("busy",  64'(busy_o),  64'(own >= 0));
      check("s_cyc", 64'(s_cyc_o), 64'(ec));
      check("s_stb", 64'(s_stb_o), 64'(es));
      check("s_we",  64'(s_we_o),  64'(ew));
      check("s_adr", 64'(s_adr_o), 64'(eadr));
      check("s_dat", 64'(s_dat_o), 64'(edat));
      check("s_sel", 64'(s_sel_o), 64'(esel));
      check("m_ack", 64'(m_ack_o), 64'(ea));
      check("m_err", 64'(m_err_o), 64'(ee));
      check("m_dat", 64'(m_dat_o), 64'(s_dat_i));
   endtask

   task automatic model_step();
      bit tmo, live, found;
      int c;
      if (rst_i) begin
         own = -1; last = NM - 1; wcnt = 0;
         return;
      end
      if (own < 0) begin
         wcnt  = 0;
         found = 1'b0;
         for (int i = 1; i <= NM; i++) begin
            c = (last + i) % NM;
            if (!found && m_cyc_i[c]) begin
               found = 1'b1; own = c; last = c;
            end
         end
      end else begin
         tmo  = model_tmo();
         live = m_cyc_i[own] && !tmo;
         if (live && s_ack_i) wcnt = 0;
         else if (live && m_stb_i[own]) wcnt++;
         if (!m_cyc_i[own] || tmo) own = -1;
      end
   endtask

   task automatic step();
      @(negedge clk_i);
      compare_outputs();
      cap_gnt = gnt_o;
      cap_ack = m_ack_o;
      cap_err = m_err_o;
      if (m_ack_o != '0) ack_cnt++;
      if (m_err_o[0]) err_cnt++;
      if (gnt_o != '0 && prev_gnt_zero) grant_q.push_back(gnt_o);
      prev_gnt_zero = (gnt_o == '0);
      @(posedge clk_i);
      model_step();
      #1;
   endtask

   task automatic clear_inputs();
      m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
      m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
      s_ack_i = 1'b0; s_dat_i = '0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      own = -1; last = NM - 1; wcnt = 0;
      step();
      step();
      rst_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b0;
      clear_inputs();
      #1;
      do_reset();

      // Three simultaneous requesters, each dropping cyc after its acked beat.
      grant_q.delete();
      s_ack_i = 1'b1;
      m_stb_i = '1;
      cap_ack = '0;
      for (int n = 0; n < 14; n++) begin
         m_cyc_i = ~cap_ack;
         step();
      end
      check("order_len", 64'(grant_q.size() >= 4), 64'(1));
      if (grant_q.size() >= 4) begin
         check("order0", 64'(grant_q[0]), 64'(3'b001));
         check("order1", 64'(grant_q[1]), 64'(3'b010));
         check("order2", 64'(grant_q[2]), 64'(3'b100));
         check("order3", 64'(grant_q[3]), 64'(3'b001));
      end

      // Single request from m1 with a two-cycle-late ack.
      clear_inputs();
      repeat (3) step();
      m_cyc_i = 3'b010; m_stb_i = 3'b010;
      m_adr_i[1*AW +: AW] = 32'h0000_1000;
      ack_cnt = 0;
      step();
      check("single_gnt", 64'(gnt_o), 64'(3'b010));
      check("single_adr", 64'(s_adr_o), 64'h1000);
      step();
      step();
      s_ack_i = 1'b1;
      step();
      check("single_ack", 64'(cap_ack), 64'(3'b010));
      s_ack_i = 1'b0; m_cyc_i = '0; m_stb_i = '0;
      step();
      step();
      check("single_ackcnt", 64'(ack_cnt), 64'(1));
      check("single_busy", 64'(busy_o), 64'(0));

      // Locked burst by m1 while m0 waits.
      clear_inputs();
      step();
      m_cyc_i = 3'b010; m_stb_i = 3'b010;
      step();
      m_cyc_i = 3'b011; m_stb_i = 3'b011; s_ack_i = 1'b1;
      for (int n = 0; n < 4; n++) begin
         step();
         check("burst_m0_ack", 64'(cap_ack[0]), 64'(0));
      end
      m_cyc_i = 3'b001; m_stb_i = 3'b001; s_ack_i = 1'b0;
      step();
      step();
      check("burst_m0_gnt", 64'(gnt_o), 64'(3'b001));
      step();

      // Write routing from m2; other masters' inputs must not leak through.
      clear_inputs();
      repeat (2) step();
      m_cyc_i = 3'b100; m_stb_i = 3'b100; m_we_i = 3'b100;
      m_dat_i[2*DW +: DW] = 32'hDEAD_BEEF;
      m_sel_i[2*SW +: SW] = 4'b1100;
      step();
      m_cyc_i = 3'b111; m_stb_i = 3'b111; m_we_i = 3'b100;
      m_dat_i[0 +: 2*DW] = {$urandom, $urandom};
      m_adr_i[0 +: 2*AW] = {$urandom, $urandom};
      m_sel_i[0 +: 2*SW] = 8'h33;
      #1;
      check("wr_we",  64'(s_we_o),  64'(1));
      check("wr_dat", 64'(s_dat_o), 64'hDEAD_BEEF);
      check("wr_sel", 64'(s_sel_o), 64'(4'b1100));
      step();
      step();

      // Asynchronous reset while m1 owns with an ack outstanding.
      clear_inputs();
      repeat (3) step();
      m_cyc_i = 3'b010; m_stb_i = 3'b010;
      step();
      step();
      rst_i = 1'b1;
      #1;
      check("rst_cyc", 64'(s_cyc_o), 64'(0));
      check("rst_gnt", 64'(gnt_o), 64'(0));
      own = -1; last = NM - 1; wcnt = 0;
      step();
      step();
      rst_i = 1'b0;
      m_cyc_i = 3'b011; m_stb_i = 3'b011;
      step();
      check("rst_first", 64'(gnt_o), 64'(3'b001));
      step();

`ifdef BUS_ARB_TIMEOUT_EN
      // Silent slave: watchdog pulses the owner's error and frees the bus.
      clear_inputs();
      repeat (3) step();
      m_cyc_i = 3'b001; m_stb_i = 3'b001;
      err_cnt = 0;
      step();
      step();
      m_cyc_i = 3'b011; m_stb_i = 3'b011;
      for (int n = 0; n < 8; n++) step();
      check("tmo_err_pulses", 64'(err_cnt), 64'(1));
`endif

      // Randomized masters and slave.
      clear_inputs();
      for (int n = 0; n < 3000; n++) begin
         for (int k = 0; k < NM; k++) begin
            if (m_cyc_i[k]) begin
               if ($urandom_range(3) == 0) m_cyc_i[k] = 1'b0;
            end else if ($urandom_range(2) == 0) begin
               m_cyc_i[k] = 1'b1;
            end
         end
         m_stb_i = NM'($urandom);
         m_we_i  = NM'($urandom);
         m_adr_i = {$urandom, $urandom, $urandom};
         m_dat_i = {$urandom, $urandom, $urandom};
         m_sel_i = (NM*SW)'($urandom);
         s_ack_i = ($urandom_range(2) == 0);
         s_dat_i = $urandom;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

`default_nettype wire
